// File: rtl/qs_pkg.sv
// Shared quadrature definitions: Gray map from 2-bit state q to {A,B} and direction encodings.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
// Used by both the quadrature generator and the quadrature decoder so both ends agree on phase order.
package qs_pkg;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   // {A,B} per quadrature state; forward order is A rises, B rises, A falls, B falls.
   localparam logic [1:0] QUAD_GRAY [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   function automatic logic [1:0] quad_gray(input logic [1:0] q);
      return QUAD_GRAY[q];
   endfunction

endpackage

// File: rtl/qs_dwell_timer.sv
// Saturating dwell counter: measures clocks since the last output edge, ready once MAX_COUNT is reached.
// Latency: clear takes effect on the next clock; ready is a registered-count compare.
// Backpressure: none; clear always wins over counting.
// Ports: clk, reset (sync, active-high, loads MAX_COUNT so the timer starts ready),
//        clear (restart from 0), ready (count has reached MAX_COUNT).
module qs_dwell_timer #(
   parameter int unsigned MAX_COUNT = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic ready
);

   localparam int unsigned TW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
   localparam logic [TW-1:0] MAX_C = TW'(MAX_COUNT);

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= MAX_C;
      end else if (clear) begin
         count <= '0;
      end else if (count != MAX_C) begin
         count <= count + TW'(1);
      end
   end

   // Count never exceeds MAX_C, so equality is the same as >=.
   assign ready = (count == MAX_C);

endmodule

// File: rtl/quadrature_generator.sv
// Step/direction to two-phase quadrature converter with a signed pending-step queue and position counter.
// Latency: step rising edge sampled at clock k updates pending at k; phase edge at k+1 when the dwell timer is ready.
// Backpressure: none upstream; excess steps queue in pending, and steps beyond its range are dropped with sticky overflow.
// Ports: clk, reset (sync, active-high), step_in, dir_in (1=forward), enable (0 freezes outputs),
//        phaseA/phaseB (quadrature out), busy (steps queued), overflow (sticky drop flag), position (net edges).
module quadrature_generator
   import qs_pkg::*;
#(
   parameter int unsigned MIN_EDGE_CLKS = 8,
   parameter int unsigned PEND_W        = 4,
   parameter int unsigned POS_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_in,
   input  logic             dir_in,
   input  logic             enable,
   output logic             phaseA,
   output logic             phaseB,
   output logic             busy,
   output logic             overflow,
   output logic [POS_W-1:0] position
);

   localparam int unsigned XW = PEND_W + 2;   // headroom for pending + d - e without wrap
   localparam int          PEND_MAX = 2 ** (PEND_W - 1) - 1;
   localparam logic signed [XW-1:0] LIM_P  = XW'(PEND_MAX);
   localparam logic signed [XW-1:0] LIM_N  = -LIM_P;
   localparam logic signed [XW-1:0] ONE_P  = XW'(1);
   localparam logic signed [XW-1:0] ONE_N  = XW'(-1);

   logic                     step_in_d;
   logic signed [PEND_W-1:0] pending;
   logic signed [PEND_W-1:0] pend_next;
   logic [1:0]               q;
   logic [1:0]               q_next;
   logic [1:0]               phase_ab;
   logic                     stp;
   logic                     emit;
   logic                     e_fwd;
   logic                     ready;
   logic                     drop;
   logic signed [XW-1:0]     p_ext;
   logic signed [XW-1:0]     d_ext;
   logic signed [XW-1:0]     e_ext;
   logic signed [XW-1:0]     sum_noin;
   logic signed [XW-1:0]     sum_all;

   qs_dwell_timer #(
      .MAX_COUNT (MIN_EDGE_CLKS - 1)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .clear (emit),
      .ready (ready)
   );

   always_comb begin
      stp      = step_in & ~step_in_d;
      emit     = enable & (pending != '0) & ready;
      // Emit direction follows the sign of the net queued steps.
      e_fwd    = ~pending[PEND_W-1];
      p_ext    = XW'(pending);
      d_ext    = '0;
      if (stp) begin
         d_ext = (dir_in == DIR_FWD) ? ONE_P : ONE_N;
      end
      e_ext    = '0;
      if (emit) begin
         e_ext = e_fwd ? ONE_P : ONE_N;
      end
      sum_noin = p_ext - e_ext;
      sum_all  = sum_noin + d_ext;
      // Only the incoming step can push past the range; an emit always moves toward zero.
      drop      = stp & ((sum_all > LIM_P) | (sum_all < LIM_N));
      pend_next = drop ? sum_noin[PEND_W-1:0] : sum_all[PEND_W-1:0];
      q_next    = q;
      if (emit) begin
         q_next = e_fwd ? (q + 2'd1) : (q - 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // A step_in held high through reset must not count as a new step.
         step_in_d <= 1'b1;
         pending   <= '0;
         q         <= 2'd0;
         phase_ab  <= 2'b00;
         position  <= '0;
         overflow  <= 1'b0;
      end else begin
         step_in_d <= step_in;
         pending   <= pend_next;
         q         <= q_next;
         phase_ab  <= quad_gray(q_next);
         if (drop) begin
            overflow <= 1'b1;
         end
         if (emit) begin
            position <= e_fwd ? (position + POS_W'(1)) : (position - POS_W'(1));
         end
      end
   end

   assign phaseA = phase_ab[1];
   assign phaseB = phase_ab[0];
   assign busy   = (pending != '0);

endmodule

// File: tb/tb_quadrature_generator.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against
// an integer-arithmetic reference model compared every cycle on the falling edge.
// Outputs: one summary line with error and check counts.
module tb_quadrature_generator;

   localparam int MIN  = 8;
   localparam int PMAX = 7;

   logic        clk;
   logic        reset;
   logic        step_in;
   logic        dir_in;
   logic        enable;
   logic        phaseA;
   logic        phaseB;
   logic        busy;
   logic        overflow;
   logic [31:0] position;

   int errors = 0;
   int checks = 0;

   quadrature_generator #(
      .MIN_EDGE_CLKS (8),
      .PEND_W        (4),
      .POS_W         (32)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .step_in  (step_in),
      .dir_in   (dir_in),
      .enable   (enable),
      .phaseA   (phaseA),
      .phaseB   (phaseB),
      .busy     (busy),
      .overflow (overflow),
      .position (position)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   // pend: net queued steps; gap: clocks since last edge (capped); pos: net edges as an integer.
   int     m_pend  = 0;
   int     m_gap   = MIN;
   longint m_pos   = 0;
   bit     m_ovf   = 0;
   bit     m_prev  = 1;
   bit     m_valid = 0;

   always @(posedge clk) begin
      int  gap;
      int  d;
      int  e;
      int  nxt;
      bit  ovf;
      if (reset) begin
         m_pend  <= 0;
         m_gap   <= MIN - 1;
         m_pos   <= 0;
         m_ovf   <= 0;
         m_prev  <= 1;
         m_valid <= 1;
      end else begin
         gap = (m_gap + 1 > MIN) ? MIN : m_gap + 1;
         d   = (step_in && !m_prev) ? (dir_in ? 1 : -1) : 0;
         e   = 0;
         if (enable && m_pend != 0 && gap >= MIN) begin
            e   = (m_pend > 0) ? 1 : -1;
            gap = 0;
         end
         nxt = m_pend + d - e;
         ovf = m_ovf;
         if (nxt > PMAX || nxt < -PMAX) begin
            nxt = m_pend - e;
            ovf = 1;
         end
         m_pend <= nxt;
         m_gap  <= gap;
         m_pos  <= m_pos + e;
         m_ovf  <= ovf;
         m_prev <= step_in;
      end
   end

   always @(negedge clk) begin
      int pm;
      if (m_valid) begin
         pm = int'(m_pos & 64'd3);
         chk("model_phaseA",   {63'd0, phaseA},   {63'd0, (pm == 1 || pm == 2)});
         chk("model_phaseB",   {63'd0, phaseB},   {63'd0, (pm == 2 || pm == 3)});
         chk("model_busy",     {63'd0, busy},     {63'd0, (m_pend != 0)});
         chk("model_overflow", {63'd0, overflow}, {63'd0, m_ovf});
         chk("model_position", {32'd0, position}, {32'd0, m_pos[31:0]});
      end
   end

   // ---------------- edge monitor ----------------
   int   cyc_cnt = 0;
   int   edge_t[$];
   logic [1:0] last_ab = 2'b00;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if ({phaseA, phaseB} !== last_ab) edge_t.push_back(cyc_cnt);
      last_ab <= {phaseA, phaseB};
   end

   task automatic step_pulse(input logic dir, input int hi, input int lo);
      dir_in  = dir;
      step_in = 1'b1;
      cyc(hi);
      step_in = 1'b0;
      cyc(lo);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset   = 1'b1;
      step_in = 1'b1;
      dir_in  = 1'b1;
      enable  = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      // Test 1: reset state, held step ignored, single forward step latency
      chk("rst_phaseA",   {63'd0, phaseA},   64'd0);
      chk("rst_phaseB",   {63'd0, phaseB},   64'd0);
      chk("rst_busy",     {63'd0, busy},     64'd0);
      chk("rst_overflow", {63'd0, overflow}, 64'd0);
      chk("rst_position", {32'd0, position}, 64'd0);
      cyc(4);
      chk("held_step_no_edge", {32'd0, position}, 64'd0);
      step_in = 1'b0;
      cyc(2);
      step_in = 1'b1;
      cyc(1);
      chk("t1_busy_queued", {63'd0, busy},   64'd1);
      chk("t1_A_not_yet",   {63'd0, phaseA}, 64'd0);
      cyc(1);
      chk("t1_AB",  {62'd0, phaseA, phaseB}, 64'b10);
      chk("t1_pos", {32'd0, position},       64'd1);
      chk("t1_busy_drop", {63'd0, busy},     64'd0);
      cyc(1);
      step_in = 1'b0;
      cyc(18);
      // Test 2: three more forward steps 20 clks apart
      step_pulse(1'b1, 2, 18);
      chk("t2_AB_2", {62'd0, phaseA, phaseB}, 64'b11);
      step_pulse(1'b1, 2, 18);
      chk("t2_AB_3", {62'd0, phaseA, phaseB}, 64'b01);
      step_pulse(1'b1, 2, 18);
      chk("t2_AB_4", {62'd0, phaseA, phaseB}, 64'b00);
      chk("t2_pos",  {32'd0, position},       64'd4);
      chk("t2_ovf",  {63'd0, overflow},       64'd0);
      // Test 3: five fast steps -> edges exactly MIN apart
      edge_t.delete();
      for (int i = 0; i < 5; i++) step_pulse(1'b1, 1, 1);
      chk("t3_busy_mid", {63'd0, busy}, 64'd1);
      cyc(60);
      chk("t3_edges", 64'(edge_t.size()), 64'd5);
      for (int i = 1; i < edge_t.size() && i < 5; i++)
         chk("t3_spacing", 64'(edge_t[i] - edge_t[i-1]), 64'd8);
      chk("t3_pos", {32'd0, position},       64'd9);
      chk("t3_AB",  {62'd0, phaseA, phaseB}, 64'b10);
      // Test 4: single reverse step from reset
      do_reset();
      cyc(2);
      step_pulse(1'b0, 2, 10);
      chk("t4_AB",  {62'd0, phaseA, phaseB}, 64'b01);
      chk("t4_pos", {32'd0, position},       64'hFFFF_FFFF);
      // Test 5: saturate pending with outputs frozen
      do_reset();
      enable = 1'b0;
      cyc(2);
      for (int i = 0; i < 9; i++) step_pulse(1'b1, 1, 1);
      cyc(4);
      chk("t5_ovf",      {63'd0, overflow},       64'd1);
      chk("t5_busy",     {63'd0, busy},           64'd1);
      chk("t5_no_edges", {32'd0, position},       64'd0);
      chk("t5_AB_froz",  {62'd0, phaseA, phaseB}, 64'b00);
      enable = 1'b1;
      cyc(70);
      chk("t5_pos",      {32'd0, position},       64'd7);
      chk("t5_ovf_stay", {63'd0, overflow},       64'd1);
      chk("t5_idle",     {63'd0, busy},           64'd0);
      // Test 6: cancel in counter, then reset mid-burst
      do_reset();
      enable = 1'b0;
      cyc(2);
      step_pulse(1'b1, 1, 1);
      step_pulse(1'b0, 1, 1);
      chk("t6_cancel_busy", {63'd0, busy}, 64'd0);
      enable = 1'b1;
      cyc(10);
      chk("t6_cancel_pos", {32'd0, position}, 64'd0);
      for (int i = 0; i < 3; i++) step_pulse(1'b1, 1, 1);
      cyc(4);
      reset = 1'b1;
      cyc(1);
      chk("t6_rst_AB",   {62'd0, phaseA, phaseB}, 64'b00);
      chk("t6_rst_pos",  {32'd0, position},       64'd0);
      chk("t6_rst_busy", {63'd0, busy},           64'd0);
      reset = 1'b0;
      cyc(30);
      chk("t6_after_pos", {32'd0, position}, 64'd0);
      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         step_in = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) dir_in = $urandom_range(0, 1);
         if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 799) == 0);
         cyc(1);
      end
      reset   = 1'b0;
      step_in = 1'b0;
      enable  = 1'b1;
      cyc(100);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
